// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Multicycle instruction sequencer. Drives the instruction address, latches the
// returned word into ir, offers it to the datapath with a ready/done handshake
// and computes the next PC (sequential, branch or jump).
//
// Optional feature macro: IFU_HALT_EN
//   defined   : opcode 111111 stops the sequencer (halted=1, pc frozen) until rst
//   undefined : opcode 111111 is an unknown opcode, halted is tied low
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   pc         out  instruction address (registered)
//   instr      in   instruction word for pc, sampled only in FETCH
//   ir         out  latched instruction register
//   ir_valid   out  instruction offered to the datapath (registered)
//   exec_ready in   datapath accepts the offered instruction
//   exec_done  in   datapath finished; cond_eq/cond_lt valid this cycle
//   cond_eq    in   rs == rt
//   cond_lt    in   signed rs < rt
//   opcode/rd/rs/rt/imm out  instruction fields decoded from ir
//   is_branch  out  ir holds BEQ/BNE/BLT
//   halted     out  sequencer stopped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [31:0]         instr,
    output logic [31:0]         ir,
    output logic                ir_valid,
    input  logic                exec_ready,
    input  logic                exec_done,
    input  logic                cond_eq,
    input  logic                cond_lt,
    output logic [5:0]          opcode,
    output logic [4:0]          rd,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [15:0]         imm,
    output logic                is_branch,
    output logic                halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_NOOP   = 3'd0,
        CL_EXEC   = 3'd1,
        CL_BRANCH = 3'd2,
        CL_JUMP   = 3'd3,
        CL_HALT   = 3'd4
    } iclass_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Sort an instruction word into the handful of paths the sequencer cares
    // about. Anything not recognised falls back to the NOOP path.
    function automatic iclass_t classify(input logic [31:0] word);
        logic [5:0] op;
        op = word[31:26];
        if (word == 32'd0) begin
            classify = CL_NOOP;
        end else if (op[5:3] == 3'b010) begin
            classify = CL_EXEC;                       // R-type
        end else if ((op[5:3] == 3'b110) && (op[2:1] != 2'b00)) begin
            classify = CL_EXEC;                       // I-type ALU
        end else if ((op >= 6'b111001) && (op <= 6'b111110)) begin
            classify = CL_EXEC;                       // memory
        end else if ((op[5:2] == 4'b1000) && (op[1:0] != 2'b11)) begin
            classify = CL_BRANCH;
        end else if (op == 6'b000001) begin
            classify = CL_JUMP;
`ifdef IFU_HALT_EN
        end else if (op == 6'b111111) begin
            classify = CL_HALT;
`endif
        end else begin
            classify = CL_NOOP;
        end
    endfunction

    // Branch condition from the low opcode bits: 00 BEQ, 01 BNE, 10 BLT.
    function automatic logic branch_taken(input logic [1:0] sel,
                                          input logic       eq,
                                          input logic       lt);
        case (sel)
            2'b00:   branch_taken = eq;
            2'b01:   branch_taken = ~eq;
            2'b10:   branch_taken = lt;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    state_t              state_r, state_s;
    logic [PC_WIDTH-1:0] pc_r, pc_s;
    logic [31:0]         ir_r, ir_s;
    logic                ir_valid_r, ir_valid_s;
`ifdef IFU_HALT_EN
    logic                halted_r, halted_s;
`endif

    iclass_t             iclass_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PC_WIDTH-1:0] jump_target_s;
    logic [PC_WIDTH-1:0] br_target_s;

    assign iclass_s      = classify(ir_r);
    assign pc_inc_s      = pc_r + PC_ONE;
    assign jump_target_s = PC_WIDTH'({6'd0, ir_r[25:0]});
    // Offset is relative to the following instruction; wraps modulo 2^PC_WIDTH.
    assign br_target_s   = pc_inc_s + PC_WIDTH'($signed(ir_r[15:0]));

    // Next-state, next-PC and handshake logic for the sequencer FSM.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        ir_valid_s = ir_valid_r;
`ifdef IFU_HALT_EN
        halted_s   = halted_r;
`endif
        case (state_r)
            ST_FETCH: begin
                ir_s    = instr;
                state_s = ST_DECODE;
            end
            ST_DECODE: begin
                case (iclass_s)
                    CL_NOOP: begin
                        pc_s    = pc_inc_s;
                        state_s = ST_FETCH;
                    end
                    CL_JUMP: begin
                        pc_s    = jump_target_s;
                        state_s = ST_FETCH;
                    end
                    CL_EXEC, CL_BRANCH: begin
                        ir_valid_s = 1'b1;
                        state_s    = ST_ISSUE;
                    end
`ifdef IFU_HALT_EN
                    CL_HALT: begin
                        halted_s = 1'b1;
                        state_s  = ST_HALTED;
                    end
`endif
                    default: begin
                        pc_s    = pc_inc_s;
                        state_s = ST_FETCH;
                    end
                endcase
            end
            ST_ISSUE: begin
                // exec_done is deliberately not looked at here.
                if (exec_ready) begin
                    ir_valid_s = 1'b0;
                    state_s    = ST_WAIT;
                end else begin
                    ir_valid_s = 1'b1;
                    state_s    = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (exec_done) begin
                    state_s = ST_FETCH;
                    if ((iclass_s == CL_BRANCH) &&
                        branch_taken(ir_r[27:26], cond_eq, cond_lt)) begin
                        pc_s = br_target_s;
                    end else begin
                        pc_s = pc_inc_s;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HALTED: begin
                // Only rst leaves this state.
                state_s = ST_HALTED;
            end
            default: begin
                ir_valid_s = 1'b0;
                state_s    = ST_FETCH;
            end
        endcase
    end

    // State and output registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            ir_r       <= 32'd0;
            ir_valid_r <= 1'b0;
`ifdef IFU_HALT_EN
            halted_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            ir_valid_r <= ir_valid_s;
`ifdef IFU_HALT_EN
            halted_r   <= halted_s;
`endif
        end
    end

    assign pc        = pc_r;
    assign ir        = ir_r;
    assign ir_valid  = ir_valid_r;
    assign opcode    = ir_r[31:26];
    assign rd        = ir_r[25:21];
    assign rs        = ir_r[20:16];
    assign rt        = ir_r[15:11];
    assign imm       = ir_r[15:0];
    assign is_branch = (ir_r[31:28] == 4'b1000) && (ir_r[27:26] != 2'b11);
`ifdef IFU_HALT_EN
    assign halted    = halted_r;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Table-driven bench for instr_fetch_unit. Each vector is one instruction with
// its handshake delays, condition flags and expected next PC. The expected PC
// is queued when the instruction is driven and popped when it retires.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ir;
    logic        ir_valid;
    logic        exec_ready;
    logic        exec_done;
    logic        cond_eq;
    logic        cond_lt;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        is_branch;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .ir(ir),
        .ir_valid(ir_valid), .exec_ready(exec_ready), .exec_done(exec_done),
        .cond_eq(cond_eq), .cond_lt(cond_lt), .opcode(opcode), .rd(rd),
        .rs(rs), .rt(rt), .imm(imm), .is_branch(is_branch), .halted(halted)
    );

    typedef struct {
        logic [31:0] word;
        int          rdly;       // extra ISSUE cycles before exec_ready
        int          ddly;       // extra WAIT cycles before exec_done
        bit          early;      // exec_done also high during ISSUE
        bit          ceq;
        bit          clt;
        bit          short_path; // NOOP/unknown/jump: no handshake
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cur_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_is_branch(input logic [31:0] w);
        return (w[31:26] == 6'b100000) || (w[31:26] == 6'b100001) || (w[31:26] == 6'b100010);
    endfunction

    // Entered at a negedge with the DUT in its FETCH cycle.
    task automatic apply(input vec_t v);
        int  ncyc;
        bit  exp_v;
        logic [31:0] e;
        ncyc = v.short_path ? 2 : 4 + v.rdly + v.ddly;
        instr   = v.word;
        cond_eq = v.ceq;
        cond_lt = v.clt;
        exp_q.push_back(v.exp_pc);
        for (int c = 1; c <= ncyc; c++) begin
            exec_ready = (c >= 3 + v.rdly);
            exec_done  = (c >= ncyc) && !v.short_path ||
                         (v.early && c >= 3 && c <= 3 + v.rdly);
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                check("ir", ir, v.word);
                check("opcode", {26'd0, opcode}, {26'd0, v.word[31:26]});
                check("rd", {27'd0, rd}, {27'd0, v.word[25:21]});
                check("rs", {27'd0, rs}, {27'd0, v.word[20:16]});
                check("rt", {27'd0, rt}, {27'd0, v.word[15:11]});
                check("imm", {16'd0, imm}, {16'd0, v.word[15:0]});
                check("is_branch", {31'd0, is_branch}, {31'd0, exp_is_branch(v.word)});
            end
            exp_v = !v.short_path && (c + 1 >= 3) && (c + 1 <= 3 + v.rdly);
            check("ir_valid", {31'd0, ir_valid}, {31'd0, exp_v});
            check("halted", {31'd0, halted}, 32'd0);
            if (c < ncyc) begin
                check("pc_hold", pc, cur_pc);
            end else begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pc_next", pc, e);
                    cur_pc = e;
                end
            end
        end
        exec_ready = 1'b0;
        exec_done  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = 32'd0; exec_ready = 1'b0; exec_done = 1'b0;
        cond_eq = 1'b0; cond_lt = 1'b0; cur_pc = 32'd0;

        //            word          rd dd early eq lt short exp_pc
        vecs.push_back('{32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1});
        vecs.push_back('{32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2});
        vecs.push_back('{32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3});
        vecs.push_back('{32'h3C000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4});
        vecs.push_back('{32'h04000001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1});
        vecs.push_back('{32'hC8210005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2});
        vecs.push_back('{32'h04000013, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd19});
        vecs.push_back('{32'h85AE0001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd21});
        vecs.push_back('{32'h04000013, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd19});
        vecs.push_back('{32'h85AE0001, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd20});
        vecs.push_back('{32'h04000006, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6});
        vecs.push_back('{32'h8801FFFD, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4});
        vecs.push_back('{32'h04000006, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6});
        vecs.push_back('{32'h8801FFFD, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd7});
        vecs.push_back('{32'h0400001A, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd26});
        vecs.push_back('{32'h04000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        vecs.push_back('{32'h8000FFFE, 5, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF});
        vecs.push_back('{32'h40000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{32'hE4000000, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{32'h80000005, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2});
        vecs.push_back('{32'hDC000000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3});
        vecs.push_back('{32'hC4000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4});
        vecs.push_back('{32'h8C000005, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5});

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_is_branch", {31'd0, is_branch}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset while waiting for exec_done, with exec_done raised in the same cycle.
        instr = 32'hC8210005; exec_ready = 1'b1; exec_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("wait_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("wait_pc", pc, cur_pc);
        rst = 1'b1; exec_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; exec_ready = 1'b0; exec_done = 1'b0;
        check("rstw_pc", pc, 32'd0);
        check("rstw_ir", ir, 32'd0);
        check("rstw_ir_valid", {31'd0, ir_valid}, 32'd0);
        cur_pc = 32'd0;
        apply('{32'h00000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1});

        // Opcode 111111.
`ifdef IFU_HALT_EN
        instr = 32'hFC000000;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, cur_pc);
        for (int k = 0; k < 20; k++) begin
            instr      = $urandom;
            exec_ready = 1'($urandom_range(0, 1));
            exec_done  = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("halt_hold_pc", pc, cur_pc);
            check("halt_hold_flag", {31'd0, halted}, 32'd1);
            check("halt_ir_valid", {31'd0, ir_valid}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; exec_ready = 1'b0; exec_done = 1'b0;
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        check("unhalt_pc", pc, 32'd0);
`else
        apply('{32'hFC000000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, cur_pc + 32'd1});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle instruction sequencer. It is the consumer side of the instruction memory interface: it drives the PC address and latches the returned 32-bit instruction.
- Decodes the instruction fields and issues each instruction to the datapath with a ready/done handshake.
- Computes the next PC (sequential, branch, jump) using compare flags supplied by the datapath.

Parameters:
- RESET_PC, 0: PC value loaded on reset.
- PC_WIDTH, 32: width of the PC and instruction-word address.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  PC_WIDTH  instruction address to instruction memory; registered.
- instr  input  32  instruction word returned for pc; combinational, valid in the same cycle.
- ir  output  32  latched instruction register.
- ir_valid  output  1  instruction offered to datapath.
- exec_ready  input  1  datapath accepts the offered instruction.
- exec_done  input  1  datapath finished the instruction; compare flags are valid this cycle.
- cond_eq  input  1  rs == rt from datapath, sampled only with exec_done.
- cond_lt  input  1  signed rs < rt from datapath, sampled only with exec_done.
- opcode  output  6  ir[31:26].
- rd  output  5  ir[25:21].
- rs  output  5  ir[20:16].
- rt  output  5  ir[15:11].
- imm  output  16  ir[15:0].
- is_branch  output  1  opcode is 100000, 100001 or 100010.
- halted  output  1  sequencer stopped (see Optional Feature).

Behaviour:
- Reset values:
  - pc=RESET_PC, ir=0, ir_valid=0, halted=0, state=FETCH.
  - Field outputs derive from ir, so they are all 0.
  - Reset has priority in every state, including mid-handshake; it takes effect at the next edge.
- Field outputs and is_branch: combinational from ir, stable while ir is held.
- Opcode classes:
  - NOOP: ir==0.
  - R-type: 010000..010111.
  - I-type ALU: 110010..110111.
  - Memory: 111001..111110 (LI, LUI, LWI, SWI, LW, SW).
  - Branch: 100000 BEQ, 100001 BNE, 100010 BLT.
  - Jump: 000001.
  - Any other opcode is treated as NOOP.
- FSM states and transitions:
  - FETCH (1 cycle): ir <= instr; go to DECODE.
  - DECODE (1 cycle):
    - NOOP or unknown: pc <= pc+1, go to FETCH.
    - Jump: pc <= zero-extended ir[25:0], go to FETCH.
    - Otherwise: go to ISSUE.
  - ISSUE: ir_valid=1. Hold until exec_ready=1, then go to WAIT with ir_valid=0 from that edge. exec_done is ignored in ISSUE.
  - WAIT: hold until exec_done=1, then update pc and go to FETCH.
    - Non-branch: pc <= pc+1.
    - Branch taken: pc <= pc+1+sign_extend(imm).
    - Taken conditions: BEQ when cond_eq; BNE when !cond_eq; BLT when cond_lt.
- Latency, best case (exec_ready and exec_done each high at first opportunity):
  - NOOP or Jump: 2 cycles.
  - Other instructions: 4 cycles.
  - Each extra stall cycle adds exactly one cycle.
- Arithmetic: all PC math is modulo 2^PC_WIDTH. pc+1 at all-ones wraps to 0; negative offsets wrap identically.
- Stability: pc and ir never change outside the edges listed above. instr is sampled only in FETCH.

Optional Feature:
- Macro: IFU_HALT_EN.
- Defined:
  - Opcode 111111 in DECODE enters state HALTED; halted=1 and pc is frozen.
  - In HALTED, ir_valid=0 and all inputs are ignored; the state is left only by rst.
- Undefined: opcode 111111 is an unknown opcode (NOOP path) and halted is tied to 0.

Test Plan:
- Reset, then instr=0 at every address -> pc steps 0,1,2,3 every 2 cycles; ir_valid never 1; halted=0.
- pc=1, instr=0xC8210005 (ADDI r1,r1,5), exec_ready=1, exec_done on the cycle after the handshake:
  - ir_valid high exactly 1 cycle with opcode=110010, rd=1, rs=1, imm=0x0005.
  - pc=2 four cycles after the fetch edge.
- pc=19, instr=0x85AE0001 (BNE):
  - with cond_eq=0 at exec_done -> pc=21;
  - repeat with cond_eq=1 -> pc=20.
- pc=6, instr=0x8801FFFD (BLT, offset -3):
  - cond_lt=1 -> pc=4;
  - cond_lt=0 -> pc=7;
  - pc=0xFFFFFFFF with a non-branch -> pc=0.
- pc=26, instr=0x04000000 (Jump) -> pc=0 two cycles after the fetch edge; ir_valid stays 0.
- Stall, reset and halt:
  - exec_ready low 5 cycles in ISSUE -> ir_valid stays 1 and pc unchanged.
  - rst pulsed in WAIT -> next cycle pc=RESET_PC, ir_valid=0, state FETCH.
  - With IFU_HALT_EN, instr=0xFC000000 -> halted=1 and pc frozen for 20 cycles; without the macro -> pc+1 after 2 cycles.
